// File: rtl/router_ctrl_rr.sv
// Multi-input router controller: round-robin pop arbitration, credit flow
// control toward the output FIFO, optional packet lock, DELAY-stage push pipe.
module router_ctrl_rr #(
    parameter int CLIENTS   = 4,
    parameter int WIDTH     = 32,
    parameter int DELAY     = 1,
    parameter int OUT_DEPTH = 8,
    parameter int PKT_MODE  = 0,
    localparam int IW = $clog2(CLIENTS),
    localparam int CW = $clog2(OUT_DEPTH + 1)
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [CLIENTS-1:0]       empty,
    output logic [CLIENTS-1:0]       pop,
    input  logic [CLIENTS-1:0]       in_last,
    input  logic [CLIENTS*WIDTH-1:0] data_in,
    input  logic                     credit_ret,
    output logic                     push,
    output logic                     push_last,
    output logic [WIDTH-1:0]         data_out,
    output logic [CW-1:0]            credits,
    output logic                     locked,
    output logic                     credit_err
);

    typedef enum logic {S_IDLE, S_LOCK} state_t;

    localparam logic [CW-1:0] FULL = CW'(OUT_DEPTH);

    state_t          state, state_nx;
    logic [IW-1:0]   lock_idx, lock_nx;
    logic [IW-1:0]   ptr;
    logic [IW-1:0]   gidx;
    logic            grant;
    logic            ret_ok;
    logic [DELAY:1]  st_vld;
    logic [DELAY:1]  st_last;
    logic [IW-1:0]   st_idx [1:DELAY];

    always_comb begin
        int j;
        j     = 0;
        grant = 1'b0;
        gidx  = ptr;
        if (credits != '0) begin
            if (state == S_LOCK) begin
                grant = !empty[lock_idx];
                gidx  = lock_idx;
            end else begin
                // rotating search starting just after the last grant
                for (int k = 1; k <= CLIENTS; k++) begin
                    j = (int'(ptr) + k) % CLIENTS;
                    if (!grant && !empty[j]) begin
                        grant = 1'b1;
                        gidx  = j[IW-1:0];
                    end
                end
            end
        end
    end

    always_comb begin
        state_nx = state;
        lock_nx  = lock_idx;
        if (PKT_MODE != 0 && grant) begin
            if (in_last[gidx]) begin
                state_nx = S_IDLE;
            end else begin
                state_nx = S_LOCK;
                lock_nx  = gidx;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < CLIENTS; i++) begin
            pop[i] = reset_n && grant && (gidx == IW'(i));
        end
    end

    assign ret_ok = credit_ret && (credits != FULL);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= S_IDLE;
            lock_idx <= '0;
            ptr      <= IW'(CLIENTS - 1);
        end else begin
            state    <= state_nx;
            lock_idx <= lock_nx;
            if (grant) ptr <= gidx;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            credits    <= FULL;
            credit_err <= 1'b0;
        end else begin
            if (credit_ret && !ret_ok) credit_err <= 1'b1;
            if (grant && !ret_ok) begin
                credits <= credits - CW'(1);
            end else if (!grant && ret_ok) begin
                credits <= credits + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            st_vld  <= '0;
            st_last <= '0;
            for (int k = 1; k <= DELAY; k++) st_idx[k] <= '0;
        end else begin
            st_vld[1]  <= grant;
            st_idx[1]  <= gidx;
            st_last[1] <= in_last[gidx];
            for (int k = 2; k <= DELAY; k++) begin
                st_vld[k]  <= st_vld[k-1];
                st_idx[k]  <= st_idx[k-1];
                st_last[k] <= st_last[k-1];
            end
        end
    end

    assign push      = st_vld[DELAY];
    assign push_last = st_vld[DELAY] & st_last[DELAY];
    assign locked    = (state == S_LOCK);

    always_comb begin
        data_out = '0;
        if (push) begin
            for (int i = 0; i < CLIENTS; i++) begin
                if (st_idx[DELAY] == IW'(i)) data_out = data_in[i*WIDTH +: WIDTH];
            end
        end
    end

endmodule

// File: tb/tb_router_ctrl_rr.sv
// Bench for router_ctrl_rr: word mode (DELAY=1) and packet mode (DELAY=3)
// instances share stimulus and are checked against an abstract model.
module tb_router_ctrl_rr;

    localparam int C  = 4;
    localparam int W  = 32;
    localparam int OD = 8;

    logic           clk = 1'b0;
    logic           reset_n;
    logic [C-1:0]   empty;
    logic [C-1:0]   in_last;
    logic [C*W-1:0] data_in;
    logic           credit_ret;
    logic           fix_a5;

    logic [C-1:0] pop_w  [2];
    logic         push_w [2];
    logic         last_w [2];
    logic [W-1:0] dout_w [2];
    logic [3:0]   cred_w [2];
    logic         lock_w [2];
    logic         err_w  [2];

    logic [C-1:0] pop_s  [2];
    logic         push_s [2];
    logic [W-1:0] dout_s [2];
    logic [3:0]   cred_s [2];
    logic         lock_s [2];
    logic         err_s  [2];

    int  n_chk  = 0;
    int  n_fail = 0;
    int  cyc    = 16;
    int  dly[2] = '{1, 3};
    bit  pkm[2] = '{1'b0, 1'b1};
    int  m_cred[2];
    int  m_ptr[2];
    int  m_lk[2];
    bit  m_err[2];
    bit  hv[2][16];
    int  hi[2][16];
    bit  hl[2][16];

    always #5 clk = ~clk;

    router_ctrl_rr #(
        .CLIENTS(C), .WIDTH(W), .DELAY(1), .OUT_DEPTH(OD), .PKT_MODE(0)
    ) u0 (
        .clk(clk), .reset_n(reset_n), .empty(empty), .pop(pop_w[0]),
        .in_last(in_last), .data_in(data_in), .credit_ret(credit_ret),
        .push(push_w[0]), .push_last(last_w[0]), .data_out(dout_w[0]),
        .credits(cred_w[0]), .locked(lock_w[0]), .credit_err(err_w[0])
    );

    router_ctrl_rr #(
        .CLIENTS(C), .WIDTH(W), .DELAY(3), .OUT_DEPTH(OD), .PKT_MODE(1)
    ) u1 (
        .clk(clk), .reset_n(reset_n), .empty(empty), .pop(pop_w[1]),
        .in_last(in_last), .data_in(data_in), .credit_ret(credit_ret),
        .push(push_w[1]), .push_last(last_w[1]), .data_out(dout_w[1]),
        .credits(cred_w[1]), .locked(lock_w[1]), .credit_err(err_w[1])
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            m_cred[m] = OD;
            m_ptr[m]  = C - 1;
            m_lk[m]   = -1;
            m_err[m]  = 1'b0;
            for (int s = 0; s < 16; s++) begin
                hv[m][s] = 1'b0;
                hi[m][s] = 0;
                hl[m][s] = 1'b0;
            end
        end
    endtask

    task automatic step(input logic [C-1:0] e, input logic [C-1:0] l, input logic r);
        int          e_idx;
        int          i;
        int          slot;
        bit          ret;
        logic [C-1:0] e_pop;
        logic [W-1:0] e_dat;
        empty      = e;
        in_last    = l;
        credit_ret = r;
        data_in    = {$urandom(), $urandom(), $urandom(), $urandom()};
        if (fix_a5) data_in[2*W +: W] = 32'hA5A5_A5A5;
        @(negedge clk);
        for (int m = 0; m < 2; m++) begin
            pop_s[m]  = pop_w[m];
            push_s[m] = push_w[m];
            dout_s[m] = dout_w[m];
            cred_s[m] = cred_w[m];
            lock_s[m] = lock_w[m];
            err_s[m]  = err_w[m];
            e_idx = -1;
            if (m_cred[m] > 0) begin
                if (m_lk[m] >= 0) begin
                    if (!e[m_lk[m]]) e_idx = m_lk[m];
                end else begin
                    for (int k = 1; k <= C; k++) begin
                        i = (m_ptr[m] + k) % C;
                        if (e_idx < 0 && !e[i]) e_idx = i;
                    end
                end
            end
            e_pop = '0;
            if (e_idx >= 0) e_pop[e_idx] = 1'b1;
            slot  = (cyc - dly[m]) & 15;
            e_dat = hv[m][slot] ? data_in[hi[m][slot]*W +: W] : '0;
            chk($sformatf("pop%0d", m), pop_w[m], e_pop);
            chk($sformatf("push%0d", m), push_w[m], hv[m][slot]);
            chk($sformatf("plast%0d", m), last_w[m], hv[m][slot] && hl[m][slot]);
            chk($sformatf("dout%0d", m), dout_w[m], e_dat);
            chk($sformatf("cred%0d", m), cred_w[m], m_cred[m]);
            chk($sformatf("lock%0d", m), lock_w[m], m_lk[m] >= 0);
            chk($sformatf("err%0d", m), err_w[m], m_err[m]);
            ret = r;
            if (ret && m_cred[m] == OD) begin
                m_err[m] = 1'b1;
                ret = 1'b0;
            end
            m_cred[m] = m_cred[m] + (ret ? 1 : 0) - (e_idx >= 0 ? 1 : 0);
            hv[m][cyc & 15] = (e_idx >= 0);
            hi[m][cyc & 15] = (e_idx >= 0) ? e_idx : 0;
            hl[m][cyc & 15] = (e_idx >= 0) ? l[e_idx] : 1'b0;
            if (e_idx >= 0) begin
                m_ptr[m] = e_idx;
                if (pkm[m]) m_lk[m] = l[e_idx] ? -1 : e_idx;
            end
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n    = 1'b0;
        empty      = '0;
        in_last    = '0;
        credit_ret = 1'b0;
        #2;
        for (int m = 0; m < 2; m++) begin
            chk($sformatf("rst_pop%0d", m), pop_w[m], 4'h0);
            chk($sformatf("rst_push%0d", m), push_w[m], 1'b0);
            chk($sformatf("rst_last%0d", m), last_w[m], 1'b0);
            chk($sformatf("rst_dout%0d", m), dout_w[m], 32'h0);
            chk($sformatf("rst_cred%0d", m), cred_w[m], OD);
            chk($sformatf("rst_lock%0d", m), lock_w[m], 1'b0);
            chk($sformatf("rst_err%0d", m), err_w[m], 1'b0);
        end
        @(posedge clk);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        model_reset();
    endtask

    initial begin
        fix_a5     = 1'b0;
        empty      = '1;
        in_last    = '0;
        credit_ret = 1'b0;
        data_in    = '0;
        reset_n    = 1'b1;
        #1;
        do_reset();

        // round-robin order 0,1,2,3,0
        for (int k = 0; k < 5; k++) begin
            step(4'h0, 4'hF, 1'b0);
            chk($sformatf("rr_order%0d", k), pop_s[0], 4'h1 << (k % 4));
        end

        // credit exhaustion and single-credit refill
        do_reset();
        for (int k = 0; k < 8; k++) step(4'h0, 4'hF, 1'b0);
        step(4'h0, 4'hF, 1'b0);
        chk("cr_zero", cred_s[0], 4'd0);
        chk("cr_nopop", pop_s[0], 4'h0);
        step(4'h0, 4'hF, 1'b1);
        chk("cr_ret_nopop", pop_s[0], 4'h0);
        step(4'h0, 4'hF, 1'b0);
        chk("cr_one_pop", pop_s[0] != 4'h0, 1'b1);
        step(4'h0, 4'hF, 1'b0);
        chk("cr_only_one", pop_s[0], 4'h0);
        step(4'h0, 4'hF, 1'b1);
        step(4'h0, 4'hF, 1'b1);
        chk("cr_both_pop", pop_s[0] != 4'h0, 1'b1);
        step(4'h0, 4'hF, 1'b0);
        chk("cr_both_same", cred_s[0], 4'd1);

        // DELAY=3 push of client 2 carries its data slice
        do_reset();
        fix_a5 = 1'b1;
        step(4'b1011, 4'hF, 1'b0);
        chk("d3_pop", pop_s[1], 4'b0100);
        for (int k = 1; k <= 5; k++) begin
            step(4'hF, 4'hF, 1'b0);
            chk($sformatf("d3_push%0d", k), push_s[1], k == 3);
            chk($sformatf("d3_dout%0d", k), dout_s[1], (k == 3) ? 32'hA5A5_A5A5 : 32'h0);
        end
        fix_a5 = 1'b0;

        // packet lock holds grant and stalls when the owner empties
        do_reset();
        step(4'b1101, 4'b0000, 1'b0);
        chk("pk_w1", pop_s[1], 4'b0010);
        step(4'b1100, 4'b0000, 1'b0);
        chk("pk_w2", pop_s[1], 4'b0010);
        chk("pk_locked", lock_s[1], 1'b1);
        step(4'b1100, 4'b0010, 1'b0);
        chk("pk_w3", pop_s[1], 4'b0010);
        step(4'b1100, 4'b0001, 1'b0);
        chk("pk_next0", pop_s[1], 4'b0001);
        chk("pk_unlock", lock_s[1], 1'b0);
        step(4'b1100, 4'b0000, 1'b0);
        chk("pk_start", pop_s[1], 4'b0010);
        for (int k = 0; k < 3; k++) begin
            step(4'b1110, 4'b0000, 1'b0);
            chk($sformatf("pk_stall%0d", k), pop_s[1], 4'h0);
            chk($sformatf("pk_held%0d", k), lock_s[1], 1'b1);
        end
        step(4'b1100, 4'b0010, 1'b0);
        chk("pk_end", pop_s[1], 4'b0010);

        // credit_ret while full is ignored and sticky
        do_reset();
        step(4'hF, 4'h0, 1'b1);
        for (int k = 0; k < 3; k++) begin
            step(4'hF, 4'h0, 1'b0);
            chk($sformatf("ce_err%0d", k), err_s[0], 1'b1);
            chk($sformatf("ce_cred%0d", k), cred_s[0], 4'd8);
        end

        // asynchronous reset with words in flight
        do_reset();
        for (int k = 0; k < 3; k++) step(4'h0, 4'hF, 1'b0);
        chk("ar_pre_push", push_w[1], 1'b1);
        reset_n = 1'b0;
        #1;
        chk("ar_push0", push_w[0], 1'b0);
        chk("ar_push1", push_w[1], 1'b0);
        chk("ar_cred1", cred_w[1], 4'd8);
        do_reset();
        for (int k = 0; k < 5; k++) step(4'hF, 4'hF, 1'b0);

        // random traffic
        for (int n = 0; n < 800; n++) begin
            if (n == 400) do_reset();
            step(4'($urandom()) & 4'($urandom()), 4'($urandom()),
                 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
